// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode constants and sequencer state encoding shared by the datapath and the sequencer
package cpu_pkg;
    localparam logic [7:0] OP_INP  = 8'hFC;
    localparam logic [7:0] OP_OUT  = 8'hFD;
    localparam logic [7:0] OP_JMP  = 8'hE0;
    localparam logic [7:0] OP_JC   = 8'hE1;
    localparam logic [7:0] OP_HALT = 8'hFF;
    localparam logic [4:0] REGWORK = 5'b11111;
    typedef enum logic [1:0] {FETCH, LOAD, EXEC, HALT} seq_state_t;
endpackage

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/load/execute sequencer with jump resolution, carry flag and INP/OUT stalls
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic              pmem_en,
    input  logic [DATA_W-1:0] pmem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              exec1,
    output logic              carrystatus,
    input  logic              carryout,
    input  logic              carryen,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted
);
    seq_state_t        state;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        op;
    logic [ADDR_W-1:0] target;
    logic              taken;

    assign op        = instr[15:8];
    assign target    = ADDR_W'(instr[7:0]);
    assign taken     = op == OP_JMP || (op == OP_JC && carrystatus);
    assign pmem_addr = pc;
    // Gated by rst so the enable reads 0 while reset is held, yet fetches on the first edge after release
    assign pmem_en   = state == FETCH && !rst;
    assign in_ready  = state == EXEC && op == OP_INP;
    assign out_valid = state == EXEC && op == OP_OUT;
    assign halted    = state == HALT;
    assign exec1     = state == EXEC && (op == OP_INP ? in_valid : op == OP_OUT ? out_ready : op != OP_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= '0;
            instr       <= '0;
            carrystatus <= 1'b0;
        end else begin
            if (exec1 && carryen) carrystatus <= carryout;
            case (state)
                FETCH: state <= LOAD;
                LOAD: begin
                    instr <= pmem_rdata;
                    state <= EXEC;
                end
                EXEC: begin
                    if (op == OP_HALT) state <= HALT;
                    else if (exec1) begin
                        pc    <= taken ? target : pc + 1'b1;
                        state <= FETCH;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end
endmodule
